// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: multiplier FSM encoding and iteration bound.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

  localparam logic [2:0] ITER_LAST = 3'd7;

endpackage

// File: rtl/RCA_8b.sv
// 8-bit ripple-carry adder; purely combinational.
module RCA_8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       c_out
);

  always_comb begin
    logic carry;
    carry = c_in;
    sum   = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c_out = carry;
  end

endmodule

// File: rtl/mult_8b_seq.sv
// Sequential 8x8 unsigned shift-add multiplier; one iteration per clock through a single RCA_8b.
module mult_8b_seq
  import arith_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  mult_state_t state;
  logic [7:0]  m;
  logic [7:0]  acc;
  logic [7:0]  q;
  logic [2:0]  cnt;

  logic [7:0]  add_b;
  logic [7:0]  sum;
  logic        c_out;
  logic [7:0]  acc_next;
  logic [7:0]  q_next;

  RCA_8b u_rca (
    .a    (acc),
    .b    (add_b),
    .c_in (1'b0),
    .sum  (sum),
    .c_out(c_out)
  );

  // {C,Acc,Q} <= {c_out,sum,Q} >> 1. The carry slot always receives a zero after the shift,
  // so it needs no storage; the adder's c_out lands in Acc[7].
  always_comb begin
    add_b    = q[0] ? m : 8'h00;
    acc_next = {c_out, sum[7:1]};
    q_next   = {sum[0], q[7:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc <= acc_next;
          q   <= q_next;
          cnt <= cnt + 3'd1;
          if (cnt == ITER_LAST) begin
            product <= {acc_next, q_next};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_8b_seq.sv
// Bench for mult_8b_seq: vector table, handshake corner cases and a random sweep, with a product scoreboard.
module tb_mult_8b_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_prod = '0;
  logic [15:0] mon_exp;
  logic        prev_done = 1'b0;
  logic        mon_en = 1'b0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  mult_8b_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each done pops one expected product; otherwise product must hold its last value.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (done) begin
        check("done_busy_excl", {done, busy}, 2'b10);
        check("done_width", prev_done, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 with product %0h, expected no done", product);
        end else begin
          mon_exp = exp_q.pop_front();
          check("product", product, mon_exp);
          last_prod = mon_exp;
        end
      end else begin
        check("product_hold", product, last_prod);
      end
    end
    prev_done = done;
  end

  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] e);
    int nb = 0;
    int dn = 0;
    @(negedge clk);
    start = 1'b1;
    a = ia;
    b = ib;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        dn = n;
        break;
      end
      if (busy) nb++;
    end
    if (dn == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 20 cycles, expected done at cycle 9");
    end else begin
      check("done_latency", dn, 9);
      check("busy_cycles", nb, 8);
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       got;

    vecs[0] = '{8'h00, 8'h00, 16'h0000};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'hAA, 8'h55, 16'h3872};
    vecs[3] = '{8'h0D, 8'h0B, 16'h008F};
    vecs[4] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[5] = '{8'hFF, 8'h01, 16'h00FF};
    vecs[6] = '{8'h80, 8'h80, 16'h4000};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_product", product, 16'h0000);
    @(negedge clk);
    rst       = 1'b0;
    last_prod = '0;
    mon_en    = 1'b1;

    // Table vectors; the AA*55 result must hold through the whole 0D*0B operation.
    for (int i = 0; i < 7; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].p);

    // start held high with operands toggling: only first operands used, re-accept 10 edges later.
    @(negedge clk);
    start = 1'b1;
    a = 8'h12;
    b = 8'h34;
    @(posedge clk);
    exp_q.push_back(16'h03A8);
    #1;
    a = 8'($urandom);
    b = 8'($urandom);
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      if (n == 10) exp_q.push_back(16'h000F);
      #1;
      if (n == 8) check("held_first_done", done, 1'b1);
      if (n == 9) check("held_idle_gap", {busy, done}, 2'b00);
      if (n == 10) check("held_reaccept", busy, 1'b1);
      if (n < 9) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end else if (n == 9) begin
        a = 8'h03;
        b = 8'h05;
      end
    end
    start = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 12 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("held_second_done_seen", got, 1'b1);

    // Asynchronous reset between edges after iteration 4 discards the operation.
    @(negedge clk);
    start = 1'b1;
    a = 8'h21;
    b = 8'h43;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midcalc_rst_busy", busy, 1'b0);
    check("midcalc_rst_done", done, 1'b0);
    check("midcalc_rst_product", product, 16'h0000);
    exp_q.delete();
    last_prod = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      check("no_done_after_rst", done, 1'b0);
    end
    do_op(8'h07, 8'h09, 16'h003F);

    // Random sweep against the a*b reference.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(ra, rb, 16'(ra) * 16'(rb));
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
